imm_gen_queue: RTL and testbench

//  Parametrised, queued immediate generator for the decode stage. Takes raw

---
 rtl/imm_gen_queue.sv | 203 ++++++++++++++++++++
 tb/tb_imm_gen_queue.sv | 345 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/imm_gen_queue.sv
// imm_gen_queue: decode-stage immediate generator feeding a DEPTH-entry FIFO.
// The opcode (or a one-hot ext_op override) selects the immediate format.
// The sign- or zero-extended immediate and the tag are queued for execute.
// Optional feature: define IMM_GEN_ZIMM_EN to decode the CSR zimm field.
// That feature also adds the out_zimm port.
module imm_gen_queue #(
    parameter int XLEN  = 32,
    parameter int DEPTH = 4,
    parameter int TAG_W = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   flush,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [31:0]            in_instr,
    input  logic [TAG_W-1:0]       in_tag,
    input  logic [5:0]             ext_op,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [XLEN-1:0]        out_imm,
    output logic [5:0]             out_fmt,
    output logic [TAG_W-1:0]       out_tag,
    output logic                   out_err,
`ifdef IMM_GEN_ZIMM_EN
    output logic                   out_zimm,
`endif
    output logic [$clog2(DEPTH):0] count
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int SH_W  = $clog2(XLEN);

    localparam logic [5:0] FMT_SHAMT = 6'b100000;
    localparam logic [5:0] FMT_I     = 6'b010000;
    localparam logic [5:0] FMT_S     = 6'b001000;
    localparam logic [5:0] FMT_B     = 6'b000100;
    localparam logic [5:0] FMT_U     = 6'b000010;
    localparam logic [5:0] FMT_J     = 6'b000001;

    // Format implied by the opcode; unknown opcodes give no format.
    function automatic logic [5:0] auto_fmt(input logic [31:0] instr);
        logic [5:0] fmt;
        fmt = 6'b0;
        case (instr[6:0])
            7'b0010011:             fmt = (instr[13:12] == 2'b01) ? FMT_SHAMT : FMT_I;
            7'b0000011, 7'b1100111: fmt = FMT_I;
            7'b0100011:             fmt = FMT_S;
            7'b1100011:             fmt = FMT_B;
            7'b0110111, 7'b0010111: fmt = FMT_U;
            7'b1101111:             fmt = FMT_J;
            default:                fmt = 6'b0;
        endcase
        return fmt;
    endfunction

    // Widen a signed 32-bit value to XLEN (no-op when XLEN is 32).
    function automatic logic [XLEN-1:0] sext32(input logic signed [31:0] v);
        logic signed [XLEN-1:0] w;
        w = XLEN'(v);
        return w;
    endfunction

    // Immediate assembly; every signed field is first built as a signed 32-bit value.
    function automatic logic [XLEN-1:0] form_imm(input logic [5:0] fmt, input logic [31:0] instr);
        logic [XLEN-1:0] imm;
        imm = '0;
        case (fmt)
            FMT_SHAMT: imm = XLEN'(instr[20 +: SH_W]);
            FMT_I:     imm = sext32({{20{instr[31]}}, instr[31:20]});
            FMT_S:     imm = sext32({{20{instr[31]}}, instr[31:25], instr[11:7]});
            FMT_B:     imm = sext32({{19{instr[31]}}, instr[31], instr[7], instr[30:25],
                                     instr[11:8], 1'b0});
            FMT_U:     imm = sext32({instr[31:12], 12'b0});
            FMT_J:     imm = sext32({{11{instr[31]}}, instr[31], instr[19:12], instr[20],
                                     instr[30:21], 1'b0});
            default:   imm = '0;
        endcase
        return imm;
    endfunction

    // ---- stage p0: combinational decode of the offered instruction ----
    logic [XLEN-1:0] imm_p0;
    logic [5:0]      fmt_p0;
    logic            err_p0;
`ifdef IMM_GEN_ZIMM_EN
    logic            zimm_p0;
`endif

    // Choose the format (auto, override or illegal) and form the immediate.
    always_comb begin
        imm_p0 = '0;
        fmt_p0 = 6'b0;
        err_p0 = 1'b0;
`ifdef IMM_GEN_ZIMM_EN
        zimm_p0 = 1'b0;
`endif
        if (ext_op == 6'b0) begin
            fmt_p0 = auto_fmt(in_instr);
            imm_p0 = form_imm(fmt_p0, in_instr);
`ifdef IMM_GEN_ZIMM_EN
            if (in_instr[6:0] == 7'b1110011 && in_instr[14]) begin
                imm_p0  = XLEN'(in_instr[19:15]);
                zimm_p0 = 1'b1;
            end
`endif
        end else if ($onehot(ext_op)) begin
            fmt_p0 = ext_op;
            imm_p0 = form_imm(ext_op, in_instr);
        end else begin
            err_p0 = 1'b1;
        end
    end

    // ---- FIFO storage and pointer control ----
    logic [XLEN-1:0]  mem_imm [DEPTH];
    logic [5:0]       mem_fmt [DEPTH];
    logic [TAG_W-1:0] mem_tag [DEPTH];
    logic             mem_err [DEPTH];
`ifdef IMM_GEN_ZIMM_EN
    logic             mem_zimm [DEPTH];
`endif

    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] head_idx;
    logic [CNT_W-1:0] count_nxt;
    logic [CNT_W-1:0] held;
    logic             push;
    logic             pop;
    logic             bypass;

    // A full FIFO refuses input even when it is popped in the same cycle.
    assign in_ready  = (count < CNT_W'(DEPTH));
    assign push      = in_valid & in_ready & ~flush;
    assign pop       = out_valid & out_ready;
    assign held      = count - CNT_W'(pop);
    assign count_nxt = count + CNT_W'(push) - CNT_W'(pop);
    assign head_idx  = rd_ptr + PTR_W'(pop);
    // Nothing stays stored after this cycle's pop, so the new head is the incoming entry.
    assign bypass    = push && (held == '0);

    // Write the decoded entry at the tail; payload storage needs no reset.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_imm[wr_ptr] <= imm_p0;
            mem_fmt[wr_ptr] <= fmt_p0;
            mem_tag[wr_ptr] <= in_tag;
            mem_err[wr_ptr] <= err_p0;
`ifdef IMM_GEN_ZIMM_EN
            mem_zimm[wr_ptr] <= zimm_p0;
`endif
        end
    end

    // Pointers, occupancy and head-valid; flush clears them and drops any push.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            out_valid <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            count     <= count_nxt;
            out_valid <= (count_nxt != '0);
        end
    end

    // ---- stage p1: registered head outputs ----
    // Load the next head; when the FIFO goes empty the last head value is held.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_imm <= '0;
            out_fmt <= 6'b0;
            out_tag <= '0;
            out_err <= 1'b0;
`ifdef IMM_GEN_ZIMM_EN
            out_zimm <= 1'b0;
`endif
        end else if (!flush && count_nxt != '0) begin
            if (bypass) begin
                out_imm <= imm_p0;
                out_fmt <= fmt_p0;
                out_tag <= in_tag;
                out_err <= err_p0;
`ifdef IMM_GEN_ZIMM_EN
                out_zimm <= zimm_p0;
`endif
            end else begin
                out_imm <= mem_imm[head_idx];
                out_fmt <= mem_fmt[head_idx];
                out_tag <= mem_tag[head_idx];
                out_err <= mem_err[head_idx];
`ifdef IMM_GEN_ZIMM_EN
                out_zimm <= mem_zimm[head_idx];
`endif
            end
        end
    end

endmodule

// File: tb/tb_imm_gen_queue.sv
// Testbench for imm_gen_queue: a 32-bit and a 64-bit instance share one stimulus
// stream and are compared against a queue-based reference model.
module tb_imm_gen_queue;
    localparam int DEPTH = 4;
    localparam int TAG_W = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             rst, flush, in_valid, out_ready;
    logic [31:0]      in_instr;
    logic [TAG_W-1:0] in_tag;
    logic [5:0]       ext_op;

    logic             in_ready_a, out_valid_a, out_err_a;
    logic [31:0]      out_imm_a;
    logic [5:0]       out_fmt_a;
    logic [TAG_W-1:0] out_tag_a;
    logic [2:0]       count_a;
    logic             in_ready_b, out_valid_b, out_err_b;
    logic [63:0]      out_imm_b;
    logic [5:0]       out_fmt_b;
    logic [TAG_W-1:0] out_tag_b;
    logic [2:0]       count_b;
`ifdef IMM_GEN_ZIMM_EN
    logic             out_zimm_a, out_zimm_b;
`endif

    imm_gen_queue #(.XLEN(32), .DEPTH(DEPTH), .TAG_W(TAG_W)) dut32 (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready_a),
        .in_instr(in_instr), .in_tag(in_tag), .ext_op(ext_op), .out_valid(out_valid_a),
        .out_ready(out_ready), .out_imm(out_imm_a), .out_fmt(out_fmt_a), .out_tag(out_tag_a),
        .out_err(out_err_a),
`ifdef IMM_GEN_ZIMM_EN
        .out_zimm(out_zimm_a),
`endif
        .count(count_a));

    imm_gen_queue #(.XLEN(64), .DEPTH(DEPTH), .TAG_W(TAG_W)) dut64 (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready_b),
        .in_instr(in_instr), .in_tag(in_tag), .ext_op(ext_op), .out_valid(out_valid_b),
        .out_ready(out_ready), .out_imm(out_imm_b), .out_fmt(out_fmt_b), .out_tag(out_tag_b),
        .out_err(out_err_b),
`ifdef IMM_GEN_ZIMM_EN
        .out_zimm(out_zimm_b),
`endif
        .count(count_b));

    // Reference model: a queue of accepted requests plus the last head shown.
    typedef struct {
        logic [31:0]      instr;
        logic [5:0]       ext;
        logic [TAG_W-1:0] tag;
    } ent_t;

    ent_t q[$];
    ent_t last;
    bit   last_zero = 1'b1;
    bit   acc;
    int   n_vec = 0;
    int   n_err = 0;

    logic             e_valid, e_ready, e_err, e_zimm;
    logic [2:0]       e_count;
    logic [31:0]      e_imm32;
    logic [63:0]      e_imm64;
    logic [5:0]       e_fmt;
    logic [TAG_W-1:0] e_tag;

    // Expected result for one request, computed with integer arithmetic.
    function automatic void model_out(input ent_t e, input int xl, output logic [63:0] imm,
                                      output logic [5:0] fmt, output logic err,
                                      output logic zimm);
        longint s;
        logic [6:0] op;
        logic [2:0] f3;
        op = e.instr[6:0];
        f3 = e.instr[14:12];
        imm = 64'd0; fmt = 6'd0; err = 1'b0; zimm = 1'b0; s = 0;
        if (e.ext == 6'd0) begin
            if (op == 7'h13)                   fmt = (f3 == 3'd1 || f3 == 3'd5) ? 6'b100000 : 6'b010000;
            else if (op == 7'h03 || op == 7'h67) fmt = 6'b010000;
            else if (op == 7'h23)              fmt = 6'b001000;
            else if (op == 7'h63)              fmt = 6'b000100;
            else if (op == 7'h37 || op == 7'h17) fmt = 6'b000010;
            else if (op == 7'h6F)              fmt = 6'b000001;
`ifdef IMM_GEN_ZIMM_EN
            else if (op == 7'h73 && f3[2]) begin
                zimm = 1'b1;
                imm  = 64'((e.instr >> 15) & 32'd31);
                return;
            end
`endif
        end else if ($countones(e.ext) == 1) begin
            fmt = e.ext;
        end else begin
            err = 1'b1;
            return;
        end
        case (fmt)
            6'b100000: s = longint'((e.instr >> 20) & ((xl == 64) ? 32'd63 : 32'd31));
            6'b010000: begin
                s = longint'((e.instr >> 20) & 32'hFFF);
                if (s >= 2048) s = s - 4096;
            end
            6'b001000: begin
                s = longint'(((e.instr >> 25) << 5) | ((e.instr >> 7) & 32'd31));
                if (s >= 2048) s = s - 4096;
            end
            6'b000100: begin
                s = longint'({e.instr[31], 12'd0}) + longint'({e.instr[7], 11'd0})
                  + longint'(((e.instr >> 25) & 32'd63) << 5) + longint'(((e.instr >> 8) & 32'd15) << 1);
                if (s >= 4096) s = s - 8192;
            end
            6'b000010: begin
                s = longint'(e.instr & 32'hFFFFF000);
                if (e.instr[31]) s = s - (longint'(1) << 32);
            end
            6'b000001: begin
                s = longint'({e.instr[31], 20'd0}) + longint'(((e.instr >> 12) & 32'd255) << 12)
                  + longint'({e.instr[20], 11'd0}) + longint'(((e.instr >> 21) & 32'd1023) << 1);
                if (s >= (longint'(1) << 20)) s = s - (longint'(1) << 21);
            end
            default: s = 0;
        endcase
        imm = (xl == 64) ? 64'(s) : {32'd0, 32'(s)};
    endfunction

    // Refresh the expected outputs from the model state.
    task automatic model_expect();
        logic [63:0] i32, i64;
        logic [5:0]  f;
        logic        er, zm;
        e_valid = (q.size() != 0);
        e_count = 3'(q.size());
        e_ready = (q.size() < DEPTH);
        if (last_zero) begin
            e_imm32 = 32'd0; e_imm64 = 64'd0; e_fmt = 6'd0; e_tag = '0; e_err = 1'b0; e_zimm = 1'b0;
        end else begin
            model_out(last, 32, i32, f, er, zm);
            model_out(last, 64, i64, f, er, zm);
            e_imm32 = i32[31:0]; e_imm64 = i64; e_fmt = f; e_err = er; e_zimm = zm; e_tag = last.tag;
        end
    endtask

    // One clock: model sees the same inputs as the DUTs, outputs sampled 1 time unit later.
    task automatic cycle();
        bit   do_push, do_pop;
        ent_t e;
        e.instr = in_instr; e.ext = ext_op; e.tag = in_tag;
        do_pop  = (q.size() != 0) && out_ready;
        do_push = in_valid && (q.size() < DEPTH) && !flush;
        acc     = do_push && !rst;
        @(posedge clk);
        #1;
        if (rst) begin
            q.delete();
            last_zero = 1'b1;
        end else if (flush) begin
            q.delete();
        end else begin
            if (do_pop) void'(q.pop_front());
            if (do_push) q.push_back(e);
        end
        if (q.size() != 0) begin
            last = q[0];
            last_zero = 1'b0;
        end
        model_expect();
    endtask

    task automatic test_reset();
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_instr = 32'd0; in_tag = '0; ext_op = 6'd0;
        cycle();
        cycle();
        rst = 1'b0;
        n_vec++; if (out_valid_a !== 1'b0) begin n_err++; $display("FAIL reset out_valid: got %b want 0", out_valid_a); end
        n_vec++; if (count_a !== 3'd0) begin n_err++; $display("FAIL reset count: got %0d want 0", count_a); end
        n_vec++; if (in_ready_a !== 1'b1) begin n_err++; $display("FAIL reset in_ready: got %b want 1", in_ready_a); end
        n_vec++; if (out_imm_a !== 32'd0) begin n_err++; $display("FAIL reset out_imm: got %h want 0", out_imm_a); end
        n_vec++; if (out_fmt_a !== 6'd0) begin n_err++; $display("FAIL reset out_fmt: got %b want 0", out_fmt_a); end
        n_vec++; if (out_tag_a !== '0) begin n_err++; $display("FAIL reset out_tag: got %h want 0", out_tag_a); end
        n_vec++; if (out_err_a !== 1'b0) begin n_err++; $display("FAIL reset out_err: got %b want 0", out_err_a); end
        n_vec++; if (out_imm_b !== 64'd0) begin n_err++; $display("FAIL reset out_imm64: got %h want 0", out_imm_b); end
        n_vec++; if (out_valid_b !== 1'b0) begin n_err++; $display("FAIL reset out_valid64: got %b want 0", out_valid_b); end
    endtask

    // Known encodings with hand-derived results; one push per cycle, consumer always ready.
    task automatic test_formats();
        logic [31:0] d_instr [10];
        logic [5:0]  d_ext   [10];
        logic [31:0] d_imm   [10];
        logic [5:0]  d_fmt   [10];
        logic        d_err   [10];
        logic [63:0] want64;
        d_instr = '{32'hFFF00093, 32'hFE112E23, 32'hFF9FF06F, 32'h123450B7, 32'h800000B7,
                    32'h00501093, 32'h00501093, 32'hFE000EE3, 32'h0000007F, 32'h0F8FD073};
        d_ext   = '{6'd0, 6'd0, 6'd0, 6'd0, 6'd0, 6'b100000, 6'b000011, 6'd0, 6'd0, 6'd0};
        d_imm   = '{32'hFFFFFFFF, 32'hFFFFFFFC, 32'hFFFFFFF8, 32'h12345000, 32'h80000000,
                    32'h00000005, 32'h0, 32'hFFFFFFFC, 32'h0, 32'h0};
        d_fmt   = '{6'b010000, 6'b001000, 6'b000001, 6'b000010, 6'b000010,
                    6'b100000, 6'b000000, 6'b000100, 6'b000000, 6'b000000};
        d_err   = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
`ifdef IMM_GEN_ZIMM_EN
        d_imm[9] = 32'h0000001F;
`endif
        out_ready = 1'b1;
        for (int v = 0; v < 10; v++) begin
            in_valid = 1'b1; in_instr = d_instr[v]; ext_op = d_ext[v]; in_tag = TAG_W'(v + 16);
            cycle();
            want64 = {{32{d_imm[v][31]}}, d_imm[v]};
            n_vec++; if (out_valid_a !== 1'b1) begin n_err++; $display("FAIL fmt%0d out_valid: got %b want 1", v, out_valid_a); end
            n_vec++; if (out_imm_a !== d_imm[v]) begin n_err++; $display("FAIL fmt%0d imm32: got %h want %h", v, out_imm_a, d_imm[v]); end
            n_vec++; if (out_fmt_a !== d_fmt[v]) begin n_err++; $display("FAIL fmt%0d fmt: got %b want %b", v, out_fmt_a, d_fmt[v]); end
            n_vec++; if (out_err_a !== d_err[v]) begin n_err++; $display("FAIL fmt%0d err: got %b want %b", v, out_err_a, d_err[v]); end
            n_vec++; if (out_tag_a !== TAG_W'(v + 16)) begin n_err++; $display("FAIL fmt%0d tag: got %h want %h", v, out_tag_a, TAG_W'(v + 16)); end
            n_vec++; if (out_imm_b !== want64) begin n_err++; $display("FAIL fmt%0d imm64: got %h want %h", v, out_imm_b, want64); end
`ifdef IMM_GEN_ZIMM_EN
            n_vec++; if (out_zimm_a !== (v == 9)) begin n_err++; $display("FAIL fmt%0d zimm: got %b want %b", v, out_zimm_a, (v == 9)); end
`endif
        end
        in_valid = 1'b0;
        cycle();
        n_vec++; if (out_valid_a !== 1'b0) begin n_err++; $display("FAIL drain out_valid: got %b want 0", out_valid_a); end
        n_vec++; if (out_imm_a !== d_imm[9]) begin n_err++; $display("FAIL empty hold imm: got %h want %h", out_imm_a, d_imm[9]); end
    endtask

    // Fill to capacity with the consumer stalled, then drain and check ordering.
    task automatic test_full_order();
        logic [TAG_W-1:0] got[$];
        out_ready = 1'b0; ext_op = 6'd0;
        for (int t = 1; t <= 4; t++) begin
            in_valid = 1'b1; in_tag = TAG_W'(t); in_instr = $urandom;
            cycle();
        end
        n_vec++; if (count_a !== 3'd4) begin n_err++; $display("FAIL full count: got %0d want 4", count_a); end
        n_vec++; if (in_ready_a !== 1'b0) begin n_err++; $display("FAIL full in_ready: got %b want 0", in_ready_a); end
        n_vec++; if (out_tag_a !== TAG_W'(1)) begin n_err++; $display("FAIL full head tag: got %0d want 1", out_tag_a); end
        in_tag = TAG_W'(5); in_instr = $urandom;
        cycle();
        n_vec++; if (count_a !== 3'd4) begin n_err++; $display("FAIL full held count: got %0d want 4", count_a); end
        out_ready = 1'b1;
        for (int k = 0; k < 12 && got.size() < 5; k++) begin
            if (out_valid_a === 1'b1) got.push_back(out_tag_a);
            cycle();
            if (acc) in_valid = 1'b0;
        end
        n_vec++; if (got.size() != 5) begin n_err++; $display("FAIL order length: got %0d want 5", got.size()); end
        for (int k = 0; k < got.size(); k++) begin
            n_vec++; if (got[k] !== TAG_W'(k + 1)) begin n_err++; $display("FAIL order tag%0d: got %0d want %0d", k, got[k], k + 1); end
        end
        in_valid = 1'b0;
        cycle();
    endtask

    // Push and pop together on a partly filled FIFO: occupancy stays put.
    task automatic test_back_to_back();
        out_ready = 1'b0; in_valid = 1'b1; ext_op = 6'd0;
        for (int k = 0; k < 2; k++) begin
            in_instr = $urandom; in_tag = TAG_W'($urandom);
            cycle();
        end
        out_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            in_instr = {$urandom_range(0, 32'hFFFFFF), 1'b0, 7'h13}; in_tag = TAG_W'($urandom);
            cycle();
            n_vec++; if (count_a !== 3'd2) begin n_err++; $display("FAIL b2b count %0d: got %0d want 2", k, count_a); end
            n_vec++; if (out_tag_a !== e_tag) begin n_err++; $display("FAIL b2b tag %0d: got %h want %h", k, out_tag_a, e_tag); end
            n_vec++; if (out_imm_a !== e_imm32) begin n_err++; $display("FAIL b2b imm %0d: got %h want %h", k, out_imm_a, e_imm32); end
        end
        in_valid = 1'b0;
        for (int k = 0; k < 3; k++) cycle();
    endtask

    // Flush with a simultaneous push: queue empties and the pushed word is lost.
    task automatic test_flush();
        out_ready = 1'b0; in_valid = 1'b1; ext_op = 6'd0;
        for (int k = 0; k < 3; k++) begin
            in_instr = {$urandom_range(0, 32'h1FFFFFF), 7'h67}; in_tag = TAG_W'($urandom);
            cycle();
        end
        n_vec++; if (count_a !== 3'd3) begin n_err++; $display("FAIL flush pre count: got %0d want 3", count_a); end
        flush = 1'b1;
        cycle();
        flush = 1'b0; in_valid = 1'b0;
        n_vec++; if (count_a !== 3'd0) begin n_err++; $display("FAIL flush count: got %0d want 0", count_a); end
        n_vec++; if (out_valid_a !== 1'b0) begin n_err++; $display("FAIL flush out_valid: got %b want 0", out_valid_a); end
        n_vec++; if (out_imm_a !== e_imm32) begin n_err++; $display("FAIL flush hold imm: got %h want %h", out_imm_a, e_imm32); end
        cycle();
        n_vec++; if (out_valid_b !== 1'b0) begin n_err++; $display("FAIL flush lost push: got %b want 0", out_valid_b); end
    endtask

    // Random traffic on both widths against the model.
    task automatic test_random();
        logic [6:0] ops [11];
        ops = '{7'h13, 7'h03, 7'h67, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6F, 7'h73, 7'h33, 7'h7F};
        for (int c = 0; c < 400; c++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 2) != 0);
            flush     = ($urandom_range(0, 31) == 0);
            in_tag    = TAG_W'($urandom);
            in_instr  = {$urandom_range(0, 32'h1FFFFFF), ops[$urandom_range(0, 10)]};
            case ($urandom_range(0, 9))
                0, 1:    ext_op = 6'(1 << $urandom_range(0, 5));
                2:       ext_op = 6'($urandom);
                default: ext_op = 6'd0;
            endcase
            cycle();
            n_vec++; if (out_valid_a !== e_valid) begin n_err++; $display("FAIL rand%0d valid: got %b want %b", c, out_valid_a, e_valid); end
            n_vec++; if (count_a !== e_count) begin n_err++; $display("FAIL rand%0d count: got %0d want %0d", c, count_a, e_count); end
            n_vec++; if (in_ready_a !== e_ready) begin n_err++; $display("FAIL rand%0d ready: got %b want %b", c, in_ready_a, e_ready); end
            n_vec++; if (out_imm_a !== e_imm32) begin n_err++; $display("FAIL rand%0d imm32: got %h want %h", c, out_imm_a, e_imm32); end
            n_vec++; if (out_fmt_a !== e_fmt) begin n_err++; $display("FAIL rand%0d fmt: got %b want %b", c, out_fmt_a, e_fmt); end
            n_vec++; if (out_tag_a !== e_tag) begin n_err++; $display("FAIL rand%0d tag: got %h want %h", c, out_tag_a, e_tag); end
            n_vec++; if (out_err_a !== e_err) begin n_err++; $display("FAIL rand%0d err: got %b want %b", c, out_err_a, e_err); end
            n_vec++; if (out_imm_b !== e_imm64) begin n_err++; $display("FAIL rand%0d imm64: got %h want %h", c, out_imm_b, e_imm64); end
            n_vec++; if (out_fmt_b !== e_fmt) begin n_err++; $display("FAIL rand%0d fmt64: got %b want %b", c, out_fmt_b, e_fmt); end
            n_vec++; if (count_b !== e_count) begin n_err++; $display("FAIL rand%0d count64: got %0d want %0d", c, count_b, e_count); end
            n_vec++; if (out_err_b !== e_err || out_tag_b !== e_tag || in_ready_b !== e_ready)
                begin n_err++; $display("FAIL rand%0d misc64: got %b/%h/%b want %b/%h/%b", c, out_err_b, out_tag_b, in_ready_b, e_err, e_tag, e_ready); end
`ifdef IMM_GEN_ZIMM_EN
            n_vec++; if (out_zimm_a !== e_zimm || out_zimm_b !== e_zimm) begin n_err++; $display("FAIL rand%0d zimm: got %b/%b want %b", c, out_zimm_a, out_zimm_b, e_zimm); end
`endif
        end
        flush = 1'b0; in_valid = 1'b0;
    endtask

    initial begin
        test_reset();
        test_formats();
        test_full_order();
        test_back_to_back();
        test_flush();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
